arch_state_checker: RTL and testbench

- Parametrised architectural-state checker for the RISC-V core simulation and FPGA-debug top.
- Watches the retiring PC. When the PC hits a programmed checkpoint, it stalls the core and scans the register file one register per cycle against an expected-value table.
- Accumulates mismatches and reports pass/fail after the last checkpoint, plus a sticky finish flag at a programmed end PC.
- Generalises the fixed three-checkpoint bench check into synthesizable logic: configurable checkpoint count, register count and width, with runtime programming.

---
 rtl/arch_state_checker.sv | 159 +++++++++++++++
 tb/tb_arch_state_checker.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/arch_state_checker.sv
// Architectural-state checker: on each programmed retire-PC checkpoint, stalls the
// core and scans the register file against an expected table, then reports pass/fail.
module arch_state_checker #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_CKPT = 3,
  parameter int ERRW     = 16,
  parameter logic [XLEN-1:0] RST_FINISH_PC = XLEN'('h0000_033c),
  localparam int RW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int CKW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
  localparam int NXW = $clog2(NUM_CKPT + 1)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [XLEN-1:0]     pc_wb,
  input  logic                pc_valid,
  output logic                hold_req,
  output logic [RW-1:0]       rf_raddr,
  input  logic [XLEN-1:0]     rf_rdata,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_sel,
  input  logic [CKW-1:0]      cfg_ckpt,
  input  logic [RW-1:0]       cfg_reg,
  input  logic [XLEN-1:0]     cfg_wdata,
  output logic [NUM_CKPT-1:0] ckpt_done,
  output logic [ERRW-1:0]     err_count,
  output logic                mismatch_valid,
  output logic [RW-1:0]       mismatch_reg,
  output logic                pass,
  output logic                fail,
  output logic                finish
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT, DONE} state_e;

  state_e              state_q, state_d;
  logic [NXW-1:0]      nxt_q, nxt_d;
  logic [RW-1:0]       raddr_q, raddr_d;
  logic [NUM_CKPT-1:0] done_q, done_d;
  logic [ERRW-1:0]     err_q, err_d;
  logic                mv_q, mv_d;
  logic [RW-1:0]       mreg_q, mreg_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                fin_q, fin_d;
  logic [XLEN-1:0]     fpc_q, fpc_d;

  // Programmable tables deliberately survive reset so a run can be replayed.
  logic [XLEN-1:0] ckpt_pc_q [NUM_CKPT];
  logic [XLEN-1:0] exp_q     [NUM_CKPT][NUM_REGS];

  logic [CKW-1:0]  ci;
  logic            cfg_ok;
  logic            ckpt_hit;
  logic            rd_mis;
  logic            last_reg;
  logic            last_ckpt;
  logic [XLEN-1:0] exp_rd;

  assign ci        = nxt_q[CKW-1:0];
  assign cfg_ok    = cfg_we && (state_q == IDLE);
  assign exp_rd    = exp_q[ci][raddr_q];
  assign rd_mis    = (rf_rdata != exp_rd);
  assign last_reg  = (raddr_q == RW'(NUM_REGS - 1));
  assign last_ckpt = (nxt_q == NXW'(NUM_CKPT - 1));
  assign ckpt_hit  = pc_valid && (nxt_q < NXW'(NUM_CKPT)) && (pc_wb == ckpt_pc_q[ci]);

  always_ff @(posedge clk) begin
    if (cfg_ok && ({1'b0, cfg_ckpt} < (CKW+1)'(NUM_CKPT))) begin
      if (cfg_sel == 2'd0) ckpt_pc_q[cfg_ckpt] <= cfg_wdata;
      if (cfg_sel == 2'd1) exp_q[cfg_ckpt][cfg_reg] <= cfg_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    raddr_d = raddr_q;
    done_d  = done_q;
    err_d   = err_q;
    mv_d    = 1'b0;
    mreg_d  = mreg_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    fin_d   = fin_q | (pc_valid && (pc_wb == fpc_q));
    fpc_d   = (cfg_ok && cfg_sel == 2'd2) ? cfg_wdata : fpc_q;
    unique case (state_q)
      IDLE: begin
        if (ckpt_hit) begin
          state_d = SCAN;
          raddr_d = '0;
        end
      end
      SCAN: begin
        if (rd_mis) begin
          mv_d   = 1'b1;
          mreg_d = raddr_q;
          if (err_q != {ERRW{1'b1}}) err_d = err_q + ERRW'(1);
        end
        raddr_d = raddr_q + RW'(1);
        if (last_reg) state_d = REPORT;
      end
      REPORT: begin
        // err_q already includes the final register's compare here.
        done_d = done_q | (NUM_CKPT'(1) << ci);
        nxt_d  = nxt_q + NXW'(1);
        if (last_ckpt) begin
          pass_d  = (err_q == '0);
          fail_d  = (err_q != '0);
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      nxt_q   <= '0;
      raddr_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      mv_q    <= 1'b0;
      mreg_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      fin_q   <= 1'b0;
      fpc_q   <= RST_FINISH_PC;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      raddr_q <= raddr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mv_q    <= mv_d;
      mreg_q  <= mreg_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      fin_q   <= fin_d;
      fpc_q   <= fpc_d;
    end
  end

  // Decoded from the state register so reset drops the stall asynchronously.
  assign hold_req       = (state_q == SCAN) || (state_q == REPORT);
  assign rf_raddr       = raddr_q;
  assign ckpt_done      = done_q;
  assign err_count      = err_q;
  assign mismatch_valid = mv_q;
  assign mismatch_reg   = mreg_q;
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign finish         = fin_q;

endmodule

// File: tb/tb_arch_state_checker.sv
// Directed bench for arch_state_checker; a second instance with ERRW=2 sees an
// inverted regfile to exercise error-counter saturation.
module tb_arch_state_checker;
  localparam int NR = 32;
  localparam int CK0 = 'h104, CK1 = 'h17c, CK2 = 'h330;

  logic        clk = 1'b0, nrst = 1'b0;
  logic [31:0] pc_wb = '0;
  logic        pc_valid = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0, cfg_ckpt = '0;
  logic [4:0]  cfg_reg = '0;
  logic [31:0] cfg_wdata = '0;

  logic        hold_req, hold2;
  logic [4:0]  raddr, raddr2, mreg, mreg2;
  logic [31:0] rdata, rdata2;
  logic [2:0]  done, done2;
  logic [15:0] err;
  logic [1:0]  err2;
  logic        mv, mv2, pass, fail, fin, pass2, fail2, fin2;

  logic [31:0] regs [NR];
  assign rdata  = regs[raddr];
  assign rdata2 = ~regs[raddr2];

  int tests = 0, fails = 0;
  int sb [$];

  always #5 clk = ~clk;

  arch_state_checker dut (
    .clk(clk), .nrst(nrst), .pc_wb(pc_wb), .pc_valid(pc_valid),
    .hold_req(hold_req), .rf_raddr(raddr), .rf_rdata(rdata),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ckpt(cfg_ckpt), .cfg_reg(cfg_reg),
    .cfg_wdata(cfg_wdata), .ckpt_done(done), .err_count(err),
    .mismatch_valid(mv), .mismatch_reg(mreg), .pass(pass), .fail(fail), .finish(fin)
  );

  arch_state_checker #(.ERRW(2)) dut2 (
    .clk(clk), .nrst(nrst), .pc_wb(pc_wb), .pc_valid(pc_valid),
    .hold_req(hold2), .rf_raddr(raddr2), .rf_rdata(rdata2),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ckpt(cfg_ckpt), .cfg_reg(cfg_reg),
    .cfg_wdata(cfg_wdata), .ckpt_done(done2), .err_count(err2),
    .mismatch_valid(mv2), .mismatch_reg(mreg2), .pass(pass2), .fail(fail2), .finish(fin2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, expv);
    end
  endtask

  // Each mismatch pulse must match the oldest expected register index.
  always @(negedge clk) begin
    if (nrst && mv) begin
      if (sb.size() == 0) check("mv_unexpected", {63'd0, mv}, 64'd0);
      else check("mismatch_reg", {59'd0, mreg}, 64'(sb.pop_front()));
    end
  end

  task automatic load_regs(input int k);
    for (int i = 0; i < NR; i++) regs[i] = 32'(i * 4 + k);
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [1:0] ck,
                           input logic [4:0] rg, input logic [31:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_ckpt = ck; cfg_reg = rg; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_hold(inout int h);
    while (hold_req && h < 100) begin
      @(posedge clk); #1;
      h++;
    end
  endtask

  task automatic retire(input logic [31:0] pc, output int h);
    pc_wb = pc; pc_valid = 1'b1;
    @(posedge clk); #1;
    pc_valid = 1'b0;
    h = 0;
    wait_hold(h);
  endtask

  task automatic do_reset();
    @(negedge clk); nrst = 1'b0;
    @(negedge clk); nrst = 1'b1;
    sb.delete();
  endtask

  task automatic run_prog(input int bad_ck, input int bad_reg);
    int k, h;
    bit is_ck;
    for (int p = 'h100; p <= 'h340; p += 4) begin
      k = (p <= CK0) ? 0 : (p <= CK1) ? 1 : 2;
      load_regs(k);
      if (k == bad_ck) regs[bad_reg] = 32'hDEAD;
      is_ck = (p == CK0) || (p == CK1) || (p == CK2);
      if (is_ck && k == bad_ck) sb.push_back(bad_reg);
      if (p == 'h33c) check("finish_pre", {63'd0, fin}, 64'd0);
      retire(32'(p), h);
      check(is_ck ? "hold_ckpt" : "hold_none", 64'(h), is_ck ? 64'd33 : 64'd0);
    end
  endtask

  initial begin
    int h;
    #1;
    check("rst_outs", {hold_req, raddr, done, err, mv, mreg, pass, fail, fin}, 64'd0);
    check("rst_outs2", {hold2, raddr2, done2, err2, mv2, mreg2, pass2, fail2, fin2}, 64'd0);
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;

    cfg_write(2'd0, 2'd0, 5'd0, 32'(CK0));
    cfg_write(2'd0, 2'd1, 5'd0, 32'(CK1));
    cfg_write(2'd0, 2'd2, 5'd0, 32'(CK2));
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NR; i++) cfg_write(2'd1, 2'(k), 5'(i), 32'(i * 4 + k));
    cfg_write(2'd3, 2'd0, 5'd0, 32'hFFFF_FFFF);

    // Clean run over the whole program
    run_prog(-1, 0);
    check("clean_done", 64'(done), 64'h7);
    check("clean_err", 64'(err), 64'd0);
    check("clean_passfail", {62'd0, pass, fail}, 64'b10);
    check("clean_finish", {63'd0, fin}, 64'd1);
    check("sat_err", 64'(err2), 64'd3);
    check("sat_passfail", {62'd0, pass2, fail2}, 64'b01);
    check("sat_done", 64'(done2), 64'h7);

    // x5 corrupted at checkpoint 1
    do_reset();
    run_prog(1, 5);
    check("bad_done", 64'(done), 64'h7);
    check("bad_err", 64'(err), 64'd1);
    check("bad_passfail", {62'd0, pass, fail}, 64'b01);
    check("bad_sb_drain", 64'(sb.size()), 64'd0);

    // Config write during a scan is dropped
    do_reset();
    load_regs(0);
    pc_wb = 32'(CK0); pc_valid = 1'b1;
    @(posedge clk); #1;
    pc_valid = 1'b0;
    check("cfgscan_hold", {63'd0, hold_req}, 64'd1);
    cfg_write(2'd1, 2'd0, 5'd3, 32'd0);
    h = 0;
    wait_hold(h);
    check("cfgscan_len", 64'(h), 64'd32);
    check("cfgscan_err", 64'(err), 64'd0);
    check("cfgscan_done", 64'(done), 64'h1);

    // Asynchronous reset ten cycles into the checkpoint-1 scan
    load_regs(1);
    pc_wb = 32'(CK1); pc_valid = 1'b1;
    @(posedge clk); #1;
    pc_valid = 1'b0;
    check("midrst_hold_pre", {63'd0, hold_req}, 64'd1);
    repeat (9) @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check("midrst_hold", {63'd0, hold_req}, 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk); nrst = 1'b1;

    // Out-of-order checkpoint PC is ignored; replay of checkpoint 0 uses intact tables
    retire(32'(CK1), h);
    check("ooo_hold", 64'(h), 64'd0);
    check("ooo_done", 64'(done), 64'd0);
    load_regs(0);
    retire(32'(CK0), h);
    check("replay_hold", 64'(h), 64'd33);
    check("replay_err", 64'(err), 64'd0);
    check("replay_done", 64'(done), 64'h1);
    check("replay_sb_drain", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
